// File: rtl/ps2_data_output_pkg.sv
// Shared PS/2 host-transmit definitions: FSM state encoding, command bytes
// and the frame parity helper.
package ps2_data_output_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_INHIBIT = 3'd1,
        TX_START   = 3'd2,
        TX_DATA    = 3'd3,
        TX_PARITY  = 3'd4,
        TX_STOP    = 3'd5,
        TX_ACK     = 3'd6
    } tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Bit that makes the eight data bits plus parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_data_output_if.sv
// Host-side request/status bundle and PS/2 line controls of the transmitter.
interface ps2_data_output_if;
    logic       send_req;
    logic [7:0] send_data;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done_strb;
    logic       tx_error_strb;

    modport master (
        output send_req, send_data, ps2_clk_negedge, ps2_data,
        input  ps2_clk_oe, ps2_data_oe, tx_busy, tx_done_strb, tx_error_strb
    );

    modport slave (
        input  send_req, send_data, ps2_clk_negedge, ps2_data,
        output ps2_clk_oe, ps2_data_oe, tx_busy, tx_done_strb, tx_error_strb
    );
endinterface

// File: rtl/ps2_data_output.sv
// PS/2 host-to-device transmitter: inhibits the bus, then shifts one byte out
// on device clock falling edges and reports the device ACK or a timeout.
module ps2_data_output
    import ps2_data_output_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 150000,
    parameter int unsigned CNT_W          = 18
) (
    input  logic             clk,
    input  logic             rst,
    ps2_data_output_if.slave bus
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t        state_r, state_s;
    logic [7:0]       shift_r, shift_s;
    logic             parity_r, parity_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             clk_oe_r, clk_oe_s;
    logic             data_oe_r, data_oe_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;

    // Next-state and next-output logic; the counter is shared between inhibit timing and edge timeout.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        parity_s  = parity_r;
        bit_cnt_s = bit_cnt_r;
        cnt_s     = cnt_r;
        clk_oe_s  = clk_oe_r;
        data_oe_s = data_oe_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                if (bus.send_req) begin
                    shift_s   = bus.send_data;
                    parity_s  = odd_parity(bus.send_data);
                    bit_cnt_s = 4'd0;
                    cnt_s     = '0;
                    busy_s    = 1'b1;
                    clk_oe_s  = 1'b1;
                    state_s   = TX_INHIBIT;
                end else begin
                    busy_s = 1'b0;
                end
            end
            TX_INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    cnt_s     = '0;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b1;
                    state_s   = TX_START;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_ACK: begin
                if (bus.ps2_clk_negedge) begin
                    cnt_s = '0;
                    case (state_r)
                        TX_START: begin
                            data_oe_s = ~shift_r[0];
                            shift_s   = {1'b0, shift_r[7:1]};
                            bit_cnt_s = 4'd1;
                            state_s   = TX_DATA;
                        end
                        TX_DATA: begin
                            if (bit_cnt_r == 4'd8) begin
                                data_oe_s = ~parity_r;
                                state_s   = TX_PARITY;
                            end else begin
                                data_oe_s = ~shift_r[0];
                                shift_s   = {1'b0, shift_r[7:1]};
                                bit_cnt_s = bit_cnt_r + 4'd1;
                            end
                        end
                        TX_PARITY: begin
                            data_oe_s = 1'b0;
                            state_s   = TX_STOP;
                        end
                        TX_STOP: begin
                            state_s = TX_ACK;
                        end
                        TX_ACK: begin
                            done_s  = ~bus.ps2_data;
                            err_s   = bus.ps2_data;
                            busy_s  = 1'b0;
                            state_s = TX_IDLE;
                        end
                        default: begin
                            state_s = TX_IDLE;
                        end
                    endcase
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    err_s     = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = TX_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                busy_s    = 1'b0;
                state_s   = TX_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= TX_IDLE;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            cnt_r     <= '0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            parity_r  <= parity_s;
            bit_cnt_r <= bit_cnt_s;
            cnt_r     <= cnt_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign bus.ps2_clk_oe    = clk_oe_r;
    assign bus.ps2_data_oe   = data_oe_r;
    assign bus.tx_busy       = busy_r;
    assign bus.tx_done_strb  = done_r;
    assign bus.tx_error_strb = err_r;

endmodule
